lock_code_sender: RTL and testbench

//  Initiator side of the serial door-lock code interface: latches a parallel code word, serializes it
//  MSB-first onto the lock's data_in (one bit/clk), drives submit, and classifies the lock's response as

---
 rtl/lock_code_sender_pkg.sv | 25 ++
 rtl/lock_code_shifter.sv | 37 +++
 rtl/lock_code_sender.sv | 204 ++++++++++++++++++++
 tb/tb_lock_code_sender.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_code_sender_pkg.sv
// rtl/lock_code_sender_pkg.sv - shared state encodings, defaults and helpers for the lock code sender
// Purpose: single place for the 3-bit state encoding and default code width used by the sender,
//          its shifter and the bench.
// Ports: none (package).
package lock_code_sender_pkg;

  localparam int DEFAULT_CODE_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_OPEN    = 3'd4,
    ST_RELOCK  = 3'd5,
    ST_CLEAR   = 3'd6,
    ST_LOCKOUT = 3'd7
  } state_e;

  // Saturating increment used by the consecutive-failure counter.
  function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] max);
    return (v >= max) ? max : 3'(v + 3'd1);
  endfunction

endpackage

// File: rtl/lock_code_shifter.sv
// rtl/lock_code_shifter.sv - CODE_LEN-bit parallel-in serial-out shifter, MSB first
// Purpose: holds the latched code word and presents it one bit at a time, MSB first.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-high reset, clears the shifter
//   load     in  capture par_in (has priority over shift)
//   shift    in  move the next bit into the MSB position
//   par_in   in  CODE_LEN-bit code word
//   ser_out  out current MSB (next bit to transmit)
module lock_code_shifter
  import lock_code_sender_pkg::*;
#(
  parameter int CODE_LEN = DEFAULT_CODE_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                shift,
  input  logic [CODE_LEN-1:0] par_in,
  output logic                ser_out
);

  logic [CODE_LEN-1:0] sh_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q <= '0;
    end else if (load) begin
      sh_q <= par_in;
    end else if (shift) begin
      sh_q <= {sh_q[CODE_LEN-2:0], 1'b0};
    end
  end

  assign ser_out = sh_q[CODE_LEN-1];

endmodule

// File: rtl/lock_code_sender.sv
// rtl/lock_code_sender.sv - initiator for the serial door-lock code interface
// Purpose: latches a code word on start, sends a sync submit, serializes the code MSB first,
//          waits for the lock's unlocked response and classifies pass/fail; counts consecutive
//          failures and enters a sticky lockout after MAX_TRIES of them.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start, code_in        attempt request (honoured only in IDLE) and the code to send
//   relock_req            relock request (honoured only in OPEN)
//   unlocked, locked      status from the lock FSM
//   data_out, submit      serial bit and submit strobe towards the lock
//   busy, is_open         status: busy outside IDLE/LOCKOUT, is_open while in OPEN
//   pass, fail            one-cycle result pulses
//   lockout, fail_cnt     sticky lockout flag and saturating consecutive-failure count
// Build option: LOCK_SENDER_AUTO_RELOCK_EN adds an OPEN_HOLD-cycle auto-relock timer in OPEN.
module lock_code_sender
  import lock_code_sender_pkg::*;
#(
  parameter int CODE_LEN     = DEFAULT_CODE_LEN,
  parameter int RESP_TIMEOUT = 8,
  parameter int MAX_TRIES    = 3
`ifdef LOCK_SENDER_AUTO_RELOCK_EN
  ,
  parameter int OPEN_HOLD    = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code_in,
  input  logic                relock_req,
  input  logic                unlocked,
  input  logic                locked,
  output logic                data_out,
  output logic                submit,
  output logic                busy,
  output logic                is_open,
  output logic                pass,
  output logic                fail,
  output logic                lockout,
  output logic [2:0]          fail_cnt
);

  localparam logic [2:0]  LAST_BIT = 3'(CODE_LEN - 1);
  localparam logic [15:0] WAIT_MAX = 16'(RESP_TIMEOUT);
  localparam logic [2:0]  TRY_MAX  = 3'(MAX_TRIES);

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [15:0] wait_q;
  logic [2:0]  fail_cnt_q;
  logic [2:0]  fail_cnt_d;
  logic        data_out_q;
  logic        submit_q;
  logic        busy_q;
  logic        is_open_q;
  logic        pass_q;
  logic        fail_q;
  logic        lockout_q;
`ifdef LOCK_SENDER_AUTO_RELOCK_EN
  logic [15:0] hold_q;
`endif

  logic sh_load;
  logic sh_shift;
  logic sh_bit;
  logic lock_dropped;

  assign sh_load  = (state_q == ST_IDLE) && start && !lockout_q;
  // SYNC pre-shifts so the register holds bit CODE_LEN-2 once bit CODE_LEN-1 is on data_out.
  assign sh_shift = (state_q == ST_SYNC) ||
                    ((state_q == ST_SEND) && (bit_cnt_q != LAST_BIT));
  assign fail_cnt_d = sat_inc(fail_cnt_q, TRY_MAX);
  // The lock relocked on its own (we did not submit).
  assign lock_dropped = !unlocked || locked;

  lock_code_shifter #(
    .CODE_LEN(CODE_LEN)
  ) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .load   (sh_load),
    .shift  (sh_shift),
    .par_in (code_in),
    .ser_out(sh_bit)
  );

  // Every output register is written on the edge that enters the state it belongs to,
  // so outputs always line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      wait_q     <= '0;
      fail_cnt_q <= '0;
      data_out_q <= 1'b0;
      submit_q   <= 1'b0;
      busy_q     <= 1'b0;
      is_open_q  <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      lockout_q  <= 1'b0;
`ifdef LOCK_SENDER_AUTO_RELOCK_EN
      hold_q     <= '0;
`endif
    end else begin
      data_out_q <= 1'b0;
      submit_q   <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !lockout_q) begin
            state_q  <= ST_SYNC;
            submit_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ST_SYNC: begin
          state_q    <= ST_SEND;
          bit_cnt_q  <= '0;
          data_out_q <= sh_bit;
        end
        ST_SEND: begin
          if (bit_cnt_q == LAST_BIT) begin
            state_q <= ST_WAIT;
            wait_q  <= 16'd1;
          end else begin
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            data_out_q <= sh_bit;
          end
        end
        ST_WAIT: begin
          if (unlocked) begin
            state_q    <= ST_OPEN;
            pass_q     <= 1'b1;
            is_open_q  <= 1'b1;
            fail_cnt_q <= '0;
`ifdef LOCK_SENDER_AUTO_RELOCK_EN
            hold_q     <= '0;
`endif
          end else if (wait_q == WAIT_MAX) begin
            state_q    <= ST_CLEAR;
            fail_q     <= 1'b1;
            submit_q   <= 1'b1;
            fail_cnt_q <= fail_cnt_d;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        ST_CLEAR: begin
          busy_q <= 1'b0;
          if (fail_cnt_q == TRY_MAX) begin
            state_q   <= ST_LOCKOUT;
            lockout_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_OPEN: begin
          // relock_req outranks both a simultaneous start and an external relock.
          if (relock_req) begin
            state_q   <= ST_RELOCK;
            submit_q  <= 1'b1;
            is_open_q <= 1'b0;
          end else if (lock_dropped) begin
            state_q   <= ST_IDLE;
            is_open_q <= 1'b0;
            busy_q    <= 1'b0;
          end
`ifdef LOCK_SENDER_AUTO_RELOCK_EN
          else if (hold_q == 16'(OPEN_HOLD - 1)) begin
            state_q   <= ST_RELOCK;
            submit_q  <= 1'b1;
            is_open_q <= 1'b0;
          end else begin
            hold_q <= hold_q + 16'd1;
          end
`endif
        end
        ST_RELOCK: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        ST_LOCKOUT: begin
          state_q <= ST_LOCKOUT;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = data_out_q;
  assign submit   = submit_q;
  assign busy     = busy_q;
  assign is_open  = is_open_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign lockout  = lockout_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_lock_code_sender.sv
// tb/tb_lock_code_sender.sv - randomized scoreboard bench for lock_code_sender
module tb_lock_code_sender;
  import lock_code_sender_pkg::*;

  localparam int CL = DEFAULT_CODE_LEN;
  localparam int RT = 8;
  localparam int MT = 3;
  localparam logic [CL-1:0] SECRET = 4'b1011;
`ifdef LOCK_SENDER_AUTO_RELOCK_EN
  localparam int OH = 16;
  localparam int NACT = 3;
`else
  localparam int NACT = 2;
`endif

  logic clk = 1'b0;
  logic reset, start, relock_req, unlocked, locked;
  logic [CL-1:0] code_in;
  logic data_out, submit, busy, is_open, pass, fail, lockout;
  logic [2:0] fail_cnt;

  always #5 clk = ~clk;
  assign locked = ~unlocked;

  lock_code_sender #(
    .CODE_LEN(CL), .RESP_TIMEOUT(RT), .MAX_TRIES(MT)
`ifdef LOCK_SENDER_AUTO_RELOCK_EN
    , .OPEN_HOLD(OH)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .code_in(code_in), .relock_req(relock_req),
    .unlocked(unlocked), .locked(locked), .data_out(data_out), .submit(submit), .busy(busy),
    .is_open(is_open), .pass(pass), .fail(fail), .lockout(lockout), .fail_cnt(fail_cnt)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One expected attempt outcome: code seen on the wire, result, result offset from SYNC, count.
  typedef struct {
    logic [CL-1:0] code;
    logic          ok;
    int            offset;
    int            cnt;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- monitor ----------------
  logic mon_prev_busy = 1'b0;
  logic mon_prev_submit = 1'b0;
  logic mon_cap = 1'b0;
  int mon_idx = 0;
  logic [CL-1:0] mon_code = '0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (reset) begin
      mon_cap = 1'b0;
      mon_prev_busy = 1'b0;
      mon_prev_submit = 1'b0;
    end else begin
      if (submit) check("submit_not_back_to_back", mon_prev_submit, 0);
      if (submit && busy && !mon_prev_busy) begin
        mon_cap = 1'b1;
        mon_idx = 0;
        mon_code = '0;
        check("sync_data_out_zero", data_out, 0);
      end else if (mon_cap) begin
        mon_idx++;
        if (mon_idx <= CL) mon_code = {mon_code[CL-2:0], data_out};
        if (pass || fail) begin
          mon_cap = 1'b0;
          if (exp_q.size() == 0) begin
            check("result_without_expectation", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check("serial_code", mon_code, mon_e.code);
            check("pass_flag", pass, mon_e.ok);
            check("fail_flag", fail, !mon_e.ok);
            check("result_latency", mon_idx, mon_e.offset);
            check("fail_cnt_at_result", fail_cnt, mon_e.cnt);
            check("clear_submit_with_fail", submit, fail);
          end
        end else if (mon_idx > CL + RT + 3) begin
          check("result_timeout", 0, 1);
          mon_cap = 1'b0;
        end
      end else if (pass || fail) begin
        check("result_outside_attempt", 1, 0);
      end
      mon_prev_busy = busy;
      mon_prev_submit = submit;
    end
  end

  // ---------------- reference model + driver ----------------
  int m_cnt = 0;
  logic [CL-1:0] sec_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_outputs_zero",
          {data_out, submit, busy, is_open, pass, fail, lockout, fail_cnt}, 0);
    m_cnt = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && busy; i++) tick();
    if (busy) check("idle_timeout", 1, 0);
  endtask

  // j: cycle (after the last bit) at which the lock reports unlocked, only for the right code.
  task automatic attempt(input logic [CL-1:0] code, input int j, input int action, input int dly);
    exp_t e;
    logic respond;
    respond = (code == SECRET);
    e.code = code;
    e.ok = respond && (j <= RT);
    e.offset = e.ok ? (CL + 1 + j) : (CL + 1 + RT);
    e.cnt = e.ok ? 0 : ((m_cnt + 1 > MT) ? MT : m_cnt + 1);
    m_cnt = e.cnt;
    exp_q.push_back(e);

    code_in = code;
    start = 1'b1;
    tick();
    start = 1'b0;
    code_in = CL'($urandom);
    if (respond) begin
      repeat (CL + j) tick();
      unlocked = 1'b1;
    end
    if (e.ok) begin
      tick();
      check("open_after_pass", is_open, 1);
      check("busy_in_open", busy, 1);
      if (action == 2) begin
`ifdef LOCK_SENDER_AUTO_RELOCK_EN
        int k;
        k = 0;
        while (k < OH + 4 && !submit) begin
          tick();
          k++;
        end
        check("auto_relock_delay", k, OH);
        unlocked = 1'b0;
        tick();
        check("idle_after_auto_relock", {busy, is_open, submit}, 0);
`endif
      end else begin
        repeat (dly) tick();
        check("still_open", is_open, 1);
        if (action == 0) begin
          relock_req = 1'b1;
          start = 1'($urandom_range(0, 1));
          code_in = sec_v;
          tick();
          relock_req = 1'b0;
          start = 1'b0;
          unlocked = 1'b0;
          check("relock_submit", submit, 1);
          check("relock_not_open", is_open, 0);
          tick();
          check("idle_after_relock", {busy, is_open, submit}, 0);
        end else begin
          unlocked = 1'b0;
          tick();
          check("idle_after_unlock_drop", {busy, is_open, submit}, 0);
        end
      end
    end else begin
      wait_idle();
      unlocked = 1'b0;
      check("fail_cnt_after_fail", fail_cnt, m_cnt);
      check("lockout_flag", lockout, (m_cnt == MT));
      if (m_cnt == MT) begin
        start = 1'b1;
        code_in = sec_v;
        repeat (3) tick();
        start = 1'b0;
        check("lockout_ignores_start_busy", busy, 0);
        check("lockout_no_submit", submit, 0);
        check("lockout_sticky", lockout, 1);
        do_reset();
      end
    end
  endtask

  initial begin
    sec_v = SECRET;
    reset = 1'b1;
    start = 1'b0;
    relock_req = 1'b0;
    unlocked = 1'b0;
    code_in = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_outputs_zero",
          {data_out, submit, busy, is_open, pass, fail, lockout, fail_cnt}, 0);

    attempt(SECRET, 1, 0, 0);        // right code, fastest response, relock
    attempt(4'b1001, 1, 0, 0);       // wrong code -> timeout failure
    attempt(SECRET, RT, 1, 1);       // latest accepted response, external relock
    attempt(4'b0000, 1, 0, 0);       // three wrong in a row -> lockout
    attempt(4'b1001, 1, 0, 0);
    attempt(4'b0111, 1, 0, 0);

    // reset while the second code bit is on the wire
    code_in = sec_v;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("second_bit_on_wire", data_out, sec_v[CL-2]);
    do_reset();
    attempt(SECRET, 2, 0, 2);
    attempt(SECRET, RT + 1, 0, 0);   // response one cycle too late

    for (int n = 0; n < 40; n++) begin
      attempt(($urandom_range(0, 1) == 1) ? SECRET : CL'($urandom),
              $urandom_range(1, RT + 2), $urandom_range(0, NACT - 1), $urandom_range(0, 3));
    end

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
